// File: rtl/bram_stream_reader.sv
// Streams a contiguous, wrapping block of BRAM words out of a valid/ready port.
// A 4-entry FIFO absorbs the one-cycle BRAM latency and downstream back-pressure.
module bram_stream_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [ADDR_W:0]   rd_left_r;
  logic [ADDR_W:0]   out_left_r;
  logic              rd_pend_r;
  logic [DATA_W-1:0] fifo_mem_r [4];
  logic [1:0]        wr_ptr_r;
  logic [1:0]        rd_ptr_r;
  logic [2:0]        fifo_cnt_r;

  logic              push_s;
  logic              pop_s;
  logic              last_pop_s;
  logic [2:0]        cnt_next_s;
  logic [ADDR_W:0]   rd_left_next_s;
  logic              rd_issue_s;

  assign m_valid_o = (fifo_cnt_r != 3'd0);
  assign m_data_o  = fifo_mem_r[rd_ptr_r];
  assign m_last_o  = m_valid_o && (out_left_r == LEN_ONE);

  // Next-cycle FIFO occupancy and read-issue decision; m_ready_i only reaches rd_en_o through a register.
  always_comb begin
    push_s     = rd_pend_r;
    pop_s      = m_valid_o && m_ready_i;
    last_pop_s = pop_s && (out_left_r == LEN_ONE);
    cnt_next_s = fifo_cnt_r + {2'b00, push_s} - {2'b00, pop_s};
    if (rd_en_o) begin
      rd_left_next_s = rd_left_r - LEN_ONE;
    end else begin
      rd_left_next_s = rd_left_r;
    end
    // Words already read but not yet popped, plus the read landing next cycle, must leave a free slot.
    rd_issue_s = (rd_left_next_s != {(ADDR_W+1){1'b0}}) &&
                 ((cnt_next_s + {2'b00, rd_en_o}) < 3'd4);
  end

  // Control FSM, read address generation and FIFO storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      busy_o     <= 1'b0;
      rd_en_o    <= 1'b0;
      rd_addr_o  <= {ADDR_W{1'b0}};
      done_o     <= 1'b0;
      rd_left_r  <= {(ADDR_W+1){1'b0}};
      out_left_r <= {(ADDR_W+1){1'b0}};
      rd_pend_r  <= 1'b0;
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      fifo_cnt_r <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      done_o     <= 1'b0;
      rd_pend_r  <= rd_en_o;
      fifo_cnt_r <= cnt_next_s;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= rd_data_i;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + 2'd1;
        out_left_r <= out_left_r - LEN_ONE;
      end
      case (state_r)
        IDLE: begin
          rd_en_o <= 1'b0;
          if (start_i && (len_i != {(ADDR_W+1){1'b0}})) begin
            state_r    <= READ;
            busy_o     <= 1'b1;
            rd_en_o    <= 1'b1;
            rd_addr_o  <= base_addr_i;
            rd_left_r  <= len_i;
            out_left_r <= len_i;
          end
        end
        READ: begin
          rd_left_r <= rd_left_next_s;
          rd_en_o   <= rd_issue_s;
          if (rd_en_o) begin
            rd_addr_o <= rd_addr_o + ADDR_ONE;
          end
          if (rd_left_next_s == {(ADDR_W+1){1'b0}}) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          rd_en_o <= 1'b0;
          if (last_pop_s) begin
            state_r <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_o  <= 1'b0;
          rd_en_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
